// File: rtl/command_controller_if.sv
// Bundles the UART byte stream, register file and transmit FIFO signals
// seen by command_controller; master is the controller side.
interface command_controller_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_valid;
  logic [ADDRESS_WIDTH-1:0] rf_address;
  logic                     rf_write_enable;
  logic [DATA_WIDTH-1:0]    rf_write_data;
  logic                     rf_read_enable;
  logic [DATA_WIDTH-1:0]    rf_read_data;
  logic                     rf_read_data_valid;
  logic                     tx_full;
  logic [DATA_WIDTH-1:0]    tx_data;
  logic                     tx_valid;
  logic                     frame_error;
  logic                     busy;

  modport master (
    input  rx_data, rx_valid, rf_read_data, rf_read_data_valid, tx_full,
    output rf_address, rf_write_enable, rf_write_data, rf_read_enable,
           tx_data, tx_valid, frame_error, busy
  );

  modport slave (
    output rx_data, rx_valid, rf_read_data, rf_read_data_valid, tx_full,
    input  rf_address, rf_write_enable, rf_write_data, rf_read_enable,
           tx_data, tx_valid, frame_error, busy
  );
endinterface

// File: rtl/command_controller.sv
// Decodes UART command bytes (write: op,addr,data / read: op,addr) into
// register file accesses and returns read data through the transmit FIFO.
module command_controller #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDRESS_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WRITE_COMMAND = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] READ_COMMAND  = 8'hBB
) (
  input logic                  clk,
  input logic                  reset,
  command_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_ISSUE,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t state;

  logic addr_out_of_range;
  assign addr_out_of_range = (bus.rx_data >> ADDRESS_WIDTH) != '0;

  // busy is assigned next to every state change so it tracks state exactly
  // while still coming straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      bus.rf_address      <= '0;
      bus.rf_write_data   <= '0;
      bus.rf_write_enable <= 1'b0;
      bus.rf_read_enable  <= 1'b0;
      bus.tx_data         <= '0;
      bus.tx_valid        <= 1'b0;
      bus.frame_error     <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      bus.rf_write_enable <= 1'b0;
      bus.rf_read_enable  <= 1'b0;
      bus.tx_valid        <= 1'b0;
      bus.frame_error     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == WRITE_COMMAND) begin
              state    <= WR_ADDR;
              bus.busy <= 1'b1;
            end else if (bus.rx_data == READ_COMMAND) begin
              state    <= RD_ADDR;
              bus.busy <= 1'b1;
            end else begin
              bus.frame_error <= 1'b1;
            end
          end
        end
        WR_ADDR, RD_ADDR: begin
          if (bus.rx_valid) begin
            if (addr_out_of_range) begin
              bus.frame_error <= 1'b1;
              state           <= IDLE;
              bus.busy        <= 1'b0;
            end else begin
              bus.rf_address <= bus.rx_data[ADDRESS_WIDTH-1:0];
              state          <= (state == WR_ADDR) ? WR_DATA : RD_ISSUE;
            end
          end
        end
        WR_DATA: begin
          if (bus.rx_valid) begin
            bus.rf_write_data   <= bus.rx_data;
            bus.rf_write_enable <= 1'b1;
            state               <= IDLE;
            bus.busy            <= 1'b0;
          end
        end
        RD_ISSUE: begin
          bus.frame_error    <= bus.rx_valid;
          bus.rf_read_enable <= 1'b1;
          state              <= RD_WAIT;
        end
        RD_WAIT: begin
          bus.frame_error <= bus.rx_valid;
          if (bus.rf_read_data_valid) begin
            bus.tx_data <= bus.rf_read_data;
            state       <= TX_SEND;
          end
        end
        TX_SEND: begin
          bus.frame_error <= bus.rx_valid;
          if (!bus.tx_full) begin
            bus.tx_valid <= 1'b1;
            state        <= IDLE;
            bus.busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_controller.sv
// Scoreboard bench for command_controller: expected strobes are queued as
// bytes are driven and retired by a monitor watching the DUT outputs.
module tb_command_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  command_controller_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  command_controller #(
    .DATA_WIDTH(8),
    .ADDRESS_WIDTH(4),
    .WRITE_COMMAND(8'hAA),
    .READ_COMMAND(8'hBB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Register file model: read data returned one cycle after the strobe.
  logic [7:0] mem [16];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rf_read_data_valid <= 1'b0;
      bus.rf_read_data       <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[2] <= 8'h01;
      mem[3] <= 8'h5A;
    end else begin
      bus.rf_read_data_valid <= bus.rf_read_enable;
      if (bus.rf_read_enable) bus.rf_read_data <= mem[bus.rf_address];
      if (bus.rf_write_enable) mem[bus.rf_address] <= bus.rf_write_data;
    end
  end

  int total = 0;
  int bad = 0;

  logic [11:0] exp_wr [$];
  logic [3:0]  exp_rd [$];
  logic [7:0]  exp_tx [$];
  logic        exp_fe [$];

  logic chk_lat = 1'b1;
  int   rd_cyc = 0;
  int   tx_cnt = 0;
  int   last_tx_cyc = 0;

  task automatic monitor();
    logic [11:0] ew;
    logic [3:0]  ea;
    logic [7:0]  et;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (bus.rf_write_enable || bus.rf_read_enable) begin
          total++;
          if (bus.rf_write_enable && bus.rf_read_enable) begin
            bad++;
            $display("FAIL we_re_overlap: got we=1 re=1 required not both");
          end
        end
        if (bus.rf_write_enable) begin
          total++;
          if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL write: got unexpected write addr=%h data=%h required none",
                     bus.rf_address, bus.rf_write_data);
          end else begin
            ew = exp_wr.pop_front();
            if ({bus.rf_address, bus.rf_write_data} !== ew) begin
              bad++;
              $display("FAIL write: got addr=%h data=%h required addr=%h data=%h",
                       bus.rf_address, bus.rf_write_data, ew[11:8], ew[7:0]);
            end
          end
        end
        if (bus.rf_read_enable) begin
          rd_cyc = cyc;
          total++;
          if (exp_rd.size() == 0) begin
            bad++;
            $display("FAIL read: got unexpected read addr=%h required none", bus.rf_address);
          end else begin
            ea = exp_rd.pop_front();
            if (bus.rf_address !== ea) begin
              bad++;
              $display("FAIL read: got addr=%h required addr=%h", bus.rf_address, ea);
            end
          end
        end
        if (bus.tx_valid) begin
          tx_cnt++;
          last_tx_cyc = cyc;
          total++;
          if (exp_tx.size() == 0) begin
            bad++;
            $display("FAIL tx: got unexpected tx_data=%h required none", bus.tx_data);
          end else begin
            et = exp_tx.pop_front();
            if (bus.tx_data !== et) begin
              bad++;
              $display("FAIL tx: got tx_data=%h required %h", bus.tx_data, et);
            end
          end
          if (chk_lat) begin
            total++;
            if (cyc - rd_cyc != 3) begin
              bad++;
              $display("FAIL rd_latency: got %0d cycles required 3", cyc - rd_cyc);
            end
          end
        end
        if (bus.frame_error) begin
          total++;
          if (exp_fe.size() == 0) begin
            bad++;
            $display("FAIL frame_error: got unexpected pulse required none");
          end else begin
            void'(exp_fe.pop_front());
          end
        end
      end
    end
  endtask

  // Caller is positioned at a negedge; the byte is held for one cycle.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (!bus.busy && exp_wr.size() == 0 && exp_rd.size() == 0 &&
          exp_tx.size() == 0 && exp_fe.size() == 0) break;
    end
    total++;
    if (bus.busy !== 1'b0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
        exp_tx.size() != 0 || exp_fe.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got busy=%b pending wr=%0d rd=%0d tx=%0d fe=%0d required all 0",
               name, bus.busy, exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_fe.size());
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    logic [35:0] obs;
    obs = {bus.rf_address, bus.rf_write_data, bus.rf_write_enable, bus.rf_read_enable,
           bus.tx_data, bus.tx_valid, bus.frame_error, bus.busy};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL %s: got outputs=%h required 0", name, obs);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);
    check_zero("after_reset_release");
  endtask

  task automatic test_write();
    int n0;
    n0 = tx_cnt;
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    wait_idle("write");
    total++;
    if (tx_cnt != n0) begin
      bad++;
      $display("FAIL write_no_tx: got %0d tx_valid required 0", tx_cnt - n0);
    end
  endtask

  task automatic test_read();
    chk_lat = 1'b1;
    exp_rd.push_back(4'h2);
    exp_tx.push_back(8'h01);
    send_byte(8'hBB);
    send_byte(8'h02);
    wait_idle("read");
  endtask

  task automatic test_tx_full();
    int n0;
    int fall;
    chk_lat = 1'b0;
    bus.tx_full = 1'b1;
    n0 = tx_cnt;
    exp_rd.push_back(4'h2);
    exp_tx.push_back(8'h01);
    send_byte(8'hBB);
    send_byte(8'h02);
    repeat (10) @(negedge clk);
    total++;
    if (tx_cnt != n0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL tx_full_hold: got tx=%0d busy=%b required tx=0 busy=1", tx_cnt - n0, bus.busy);
    end
    bus.tx_full = 1'b0;
    fall = cyc;
    wait_idle("tx_full");
    total++;
    if (tx_cnt != n0 + 1 || last_tx_cyc != fall + 1) begin
      bad++;
      $display("FAIL tx_full_release: got tx=%0d at cycle %0d required 1 at cycle %0d",
               tx_cnt - n0, last_tx_cyc, fall + 1);
    end
    chk_lat = 1'b1;
  endtask

  task automatic test_bad_frames();
    exp_fe.push_back(1'b1);
    exp_fe.push_back(1'b1);
    send_byte(8'h7E);
    send_byte(8'hAA);
    send_byte(8'h15);
    wait_idle("bad_frames");
    total++;
    if (bus.rf_address !== 4'h2 || bus.rf_write_data !== 8'h3C) begin
      bad++;
      $display("FAIL hold_regs: got addr=%h data=%h required addr=2 data=3c",
               bus.rf_address, bus.rf_write_data);
    end
  endtask

  task automatic test_rx_during_rd_wait();
    int n0;
    n0 = tx_cnt;
    exp_rd.push_back(4'h3);
    exp_tx.push_back(8'h5A);
    exp_fe.push_back(1'b1);
    send_byte(8'hBB);
    send_byte(8'h03);
    @(negedge clk);
    send_byte(8'h77);
    wait_idle("rx_during_rd_wait");
    total++;
    if (tx_cnt != n0 + 1) begin
      bad++;
      $display("FAIL rd_wait_single_tx: got %0d tx_valid required 1", tx_cnt - n0);
    end
  endtask

  task automatic test_back_to_back();
    exp_wr.push_back({4'h7, 8'h11});
    exp_rd.push_back(4'h7);
    exp_tx.push_back(8'h11);
    exp_wr.push_back({4'h9, 8'hAA});
    exp_rd.push_back(4'h9);
    exp_tx.push_back(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'hBB);
    send_byte(8'h07);
    repeat (4) @(negedge clk);
    send_byte(8'hAA);
    send_byte(8'h09);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'h09);
    wait_idle("back_to_back");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hAA);
    send_byte(8'h04);
    #2;
    reset = 1'b0;
    #1;
    check_zero("reset_mid_immediate");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_released");
    exp_fe.push_back(1'b1);
    send_byte(8'h3C);
    wait_idle("reset_mid");
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_full  = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_tx_full();
    test_bad_frames();
    test_rx_during_rd_wait();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
